// File: rtl/vec3_alu_seq_pkg.sv
// vec3_alu_seq_pkg: Q16.16 fixed-point types, vec3 op codes and FSM states
package vec3_alu_seq_pkg;
  localparam int FP_WIDTH = 32;
  localparam int FP_FRAC_BITS = 16;
  typedef logic signed [FP_WIDTH-1:0] fp;
  typedef struct packed {fp z; fp y; fp x;} vec3;
  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_NEG   = 3'd2,
    OP_DOT   = 3'd3,
    OP_SCALE = 3'd4
  } vec3_op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
endpackage

// File: rtl/vec3_alu_seq_fp_mul_cell.sv
// vec3_alu_seq_fp_mul_cell: combinational signed fixed-point multiply, full product rescaled and wrapped
module vec3_alu_seq_fp_mul_cell #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);
  logic signed [2*DATA_WIDTH-1:0] p;
  assign p = $signed(a) * $signed(b);
  assign y = DATA_WIDTH'(p >>> FRAC_BITS);
endmodule

// File: rtl/vec3_alu_seq.sv
// vec3_alu_seq: vec3 ADD/SUB/NEG/DOT/SCALE sequencer around one shared Q16.16 multiplier
module vec3_alu_seq
  import vec3_alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = FP_WIDTH,
  parameter int FRAC_BITS  = FP_FRAC_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [3*DATA_WIDTH-1:0] in_a,
  input  logic [3*DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0]   in_s,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3*DATA_WIDTH-1:0] out_vec,
  output logic [DATA_WIDTH-1:0]   out_scalar,
  output logic                    out_err
);
  localparam int W = DATA_WIDTH;
  state_e state;
  logic [1:0] idx;
  logic [2:0] op;
  logic [2*W-1:0] a, b;
  logic [3*W-1:0] lanes;
  logic [W-1:0] s, ma, mb, prod;
  logic mul_op, bad_op;
  assign in_ready = state == S_IDLE;
  assign bad_op = in_op > 3'd4;
  assign mul_op = in_op == OP_DOT || in_op == OP_SCALE;
  // x lane multiplies straight off the ports on the accept edge; y and z use the latched upper lanes
  always_comb begin
    ma = in_ready ? in_a[W-1:0] : idx == 2'd1 ? a[W-1:0] : a[2*W-1:W];
    mb = in_ready ? (in_op == OP_DOT ? in_b[W-1:0] : in_s) : op != OP_DOT ? s : idx == 2'd1 ? b[W-1:0] : b[2*W-1:W];
  end
  vec3_alu_seq_fp_mul_cell #(.DATA_WIDTH(W), .FRAC_BITS(FRAC_BITS)) u_mul (.a(ma), .b(mb), .y(prod));
  for (genvar g = 0; g < 3; g++) begin : g_lane
    assign lanes[g*W +: W] = in_op == OP_ADD ? in_a[g*W +: W] + in_b[g*W +: W] :
                             in_op == OP_SUB ? in_a[g*W +: W] - in_b[g*W +: W] :
                             bad_op ? '0 : -in_a[g*W +: W];
  end
  // op FSM with registered outputs; out_scalar doubles as the DOT accumulator while busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= '0;
      op <= '0;
      a <= '0;
      b <= '0;
      s <= '0;
      out_valid <= 1'b0;
      out_vec <= '0;
      out_scalar <= '0;
      out_err <= 1'b0;
    end else case (state)
      S_IDLE: if (in_valid) begin
        op <= in_op;
        a <= in_a[3*W-1:W];
        b <= in_b[3*W-1:W];
        s <= in_s;
        idx <= 2'd1;
        state <= mul_op ? S_MUL : S_DONE;
        out_valid <= !mul_op;
        out_err <= bad_op;
        out_scalar <= in_op == OP_DOT ? prod : '0;
        out_vec <= in_op == OP_SCALE ? {{(2*W){1'b0}}, prod} : in_op == OP_DOT ? '0 : lanes;
      end
      S_MUL: begin
        if (op == OP_DOT) out_scalar <= out_scalar + prod;
        else if (idx == 2'd1) out_vec[2*W-1:W] <= prod;
        else out_vec[3*W-1:2*W] <= prod;
        idx <= idx + 2'd1;
        if (idx == 2'd2) begin
          state <= S_DONE;
          out_valid <= 1'b1;
        end
      end
      default: if (out_ready) begin
        state <= S_IDLE;
        out_valid <= 1'b0;
        out_vec <= '0;
        out_scalar <= '0;
        out_err <= 1'b0;
      end
    endcase
endmodule
